// File: rtl/gain_ramp.sv
// Zipper-free gain smoother: latches per-band targets through a valid/ready
// handshake and walks the live gains toward them once every RAMP_DIV sample ticks.
module gain_ramp #(
  parameter int NUM_BANDS = 3,
  parameter int GAIN_W    = 8,
  parameter int STEP      = 1,
  parameter int RAMP_DIV  = 48,
  parameter int GAIN_INIT = 1,
  parameter int GAIN_MAX  = 127
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     mute,
  input  logic                     target_valid,
  output logic                     target_ready,
  input  logic signed [GAIN_W-1:0] target_gain [0:NUM_BANDS-1],
  output logic signed [GAIN_W-1:0] gain        [0:NUM_BANDS-1],
  output logic                     ramping
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
  localparam logic signed [GAIN_W:0]   MAX_X      = (GAIN_W+1)'(GAIN_MAX);
  localparam logic signed [GAIN_W:0]   NEG_MAX_X  = (GAIN_W+1)'(-GAIN_MAX);
  localparam logic signed [GAIN_W:0]   STEP_X     = (GAIN_W+1)'(STEP);
  localparam logic signed [GAIN_W:0]   NEG_STEP_X = (GAIN_W+1)'(-STEP);
  localparam logic signed [GAIN_W-1:0] MAX_G      = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] NEG_MAX_G  = GAIN_W'(-GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] STEP_G     = GAIN_W'(STEP);
  localparam logic signed [GAIN_W-1:0] INIT_G     = GAIN_W'(GAIN_INIT);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic signed [GAIN_W-1:0] tgt_q   [NUM_BANDS];
  logic signed [GAIN_W-1:0] tgt_d   [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_q  [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_d  [NUM_BANDS];
  logic signed [GAIN_W-1:0] eff     [NUM_BANDS];
  logic signed [GAIN_W-1:0] stepped [NUM_BANDS];
  logic signed [GAIN_W-1:0] clamped [NUM_BANDS];
  logic signed [GAIN_W:0]   diff    [NUM_BANDS];
  logic signed [GAIN_W:0]   req_x   [NUM_BANDS];
  logic                     any_diff;
  logic                     all_done;

  // Per-lane datapath: the difference is taken one bit wider so that the full
  // -GAIN_MAX..GAIN_MAX swing never wraps.
  always_comb begin
    any_diff = 1'b0;
    all_done = 1'b1;
    for (int i = 0; i < NUM_BANDS; i++) begin
      eff[i]   = mute ? '0 : tgt_q[i];
      diff[i]  = $signed({eff[i][GAIN_W-1], eff[i]}) - $signed({gain_q[i][GAIN_W-1], gain_q[i]});
      if (diff[i] > STEP_X) begin
        stepped[i] = gain_q[i] + STEP_G;
      end else if (diff[i] < NEG_STEP_X) begin
        stepped[i] = gain_q[i] - STEP_G;
      end else begin
        stepped[i] = eff[i];
      end
      any_diff = any_diff | (gain_q[i] != eff[i]);
      all_done = all_done & (stepped[i] == eff[i]);

      req_x[i] = $signed({target_gain[i][GAIN_W-1], target_gain[i]});
      if (req_x[i] > MAX_X) begin
        clamped[i] = MAX_G;
      end else if (req_x[i] < NEG_MAX_X) begin
        clamped[i] = NEG_MAX_G;
      end else begin
        clamped[i] = target_gain[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    tgt_d      = tgt_q;
    gain_d     = gain_q;
    case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d = clamped;
        end
        if (any_diff) begin
          state_d    = RAMP;
          tick_cnt_d = '0;
        end
      end
      RAMP: begin
        if (sample_tick) begin
          if (tick_cnt_q == CNT_LAST) begin
            tick_cnt_d = '0;
            gain_d     = stepped;
            if (all_done) begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        tgt_q[i]  <= INIT_G;
        gain_q[i] <= INIT_G;
      end
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tgt_q      <= tgt_d;
      gain_q     <= gain_d;
    end
  end

  assign gain         = gain_q;
  assign target_ready = (state_q == IDLE);
  assign ramping      = (state_q == RAMP);

endmodule
